// File: rtl/coin_hopper.sv
// Coin hopper payout controller.
// Takes a coin-count request from the game FSM and pulses the hopper motor
// one coin at a time. Each coin is confirmed by the synchronised exit sensor.
// Missing coins are retried a limited number of times, after which the block
// parks in JAM until the operator clears it.
module coin_hopper #(
    parameter int AMT_W       = 8,
    parameter int PULSE_CYC   = 4,
    parameter int ACK_TIMEOUT = 16,
    parameter int MAX_RETRY   = 2
) (
    input  logic             clk_i,
    input  logic             clrb_i,
    input  logic             pay_req_i,
    input  logic [AMT_W-1:0] pay_amt_i,
    input  logic             coin_sense_i,
    input  logic             jam_clr_i,
    output logic             pay_busy_o,
    output logic             motor_o,
    output logic             done_o,
    output logic             jam_o,
    output logic [AMT_W-1:0] coins_left_o,
    output logic [AMT_W-1:0] paid_cnt_o
);

    localparam int PW = (PULSE_CYC > 1) ? $clog2(PULSE_CYC) : 1;
    localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    localparam logic [PW-1:0] PULSE_LAST = PW'(PULSE_CYC - 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(ACK_TIMEOUT - 1);
    localparam logic [RW-1:0] RETRY_LAST = RW'(MAX_RETRY);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_DRIVE,
        S_WAIT,
        S_JAM,
        S_DONE
    } state_e;

    state_e state_q, state_d;

    logic             sync1_q, sync2_q, sync3_q;
    logic [AMT_W-1:0] coins_left_q, coins_left_d;
    logic [AMT_W-1:0] paid_cnt_q, paid_cnt_d;
    logic [RW-1:0]    retry_q, retry_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic [PW-1:0]    pulse_q, pulse_d;
    logic             gap_q, gap_d;

    logic sense_event;
    logic last_coin;
    logic pulse_end;
    logic timeout;
    logic retry_max;

    // Coin sensor synchroniser plus one history flop for rising-edge detection
    always_ff @(posedge clk_i or negedge clrb_i) begin
        if (!clrb_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            sync3_q <= 1'b0;
        end else begin
            sync1_q <= coin_sense_i;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
        end
    end

    // A coin only counts while a payout is actively dispensing or jammed;
    // a held-high sensor yields a single rising edge and so a single count.
    // The gap cycle after a confirmed coin keeps the motor low between pulses.
    always_comb begin
        sense_event = sync2_q && !sync3_q &&
                      ((state_q == S_DRIVE) || (state_q == S_WAIT) || (state_q == S_JAM));
        last_coin   = (coins_left_q == AMT_W'(1));
        pulse_end   = !gap_q && (pulse_q == PULSE_LAST);
        timeout     = (timer_q == TIMER_LAST);
        retry_max   = (retry_q == RETRY_LAST);
    end

    // State register
    always_ff @(posedge clk_i or negedge clrb_i) begin
        if (!clrb_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a sense event always takes priority over timers and jam_clr
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (pay_req_i) state_d = S_LOAD;
            end
            S_LOAD: begin
                state_d = (coins_left_q == '0) ? S_DONE : S_DRIVE;
            end
            S_DRIVE: begin
                if (sense_event)    state_d = last_coin ? S_DONE : S_DRIVE;
                else if (pulse_end) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (sense_event)  state_d = last_coin ? S_DONE : S_DRIVE;
                else if (timeout) state_d = retry_max ? S_JAM : S_DRIVE;
            end
            S_JAM: begin
                if (sense_event && last_coin) state_d = S_DONE;
                else if (jam_clr_i)           state_d = S_DRIVE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath next values: coin counters, retry count, wait timer, pulse timer
    always_comb begin
        coins_left_d = coins_left_q;
        paid_cnt_d   = paid_cnt_q;
        retry_d      = retry_q;
        timer_d      = '0;
        pulse_d      = '0;
        gap_d        = 1'b0;

        if ((state_q == S_IDLE) && pay_req_i) begin
            coins_left_d = pay_amt_i;
            paid_cnt_d   = '0;
            retry_d      = '0;
        end

        if (sense_event) begin
            coins_left_d = coins_left_q - AMT_W'(1);
            paid_cnt_d   = paid_cnt_q + AMT_W'(1);
            retry_d      = '0;
        end else if ((state_q == S_WAIT) && timeout && !retry_max) begin
            retry_d = retry_q + RW'(1);
        end else if ((state_q == S_JAM) && jam_clr_i) begin
            retry_d = '0;
        end

        if ((state_q == S_WAIT) && (state_d == S_WAIT)) begin
            timer_d = timer_q + TW'(1);
        end

        if (state_d == S_DRIVE) begin
            if ((state_q != S_DRIVE) || sense_event) begin
                gap_d = sense_event;
            end else if (gap_q) begin
                gap_d = 1'b0;
            end else begin
                pulse_d = pulse_q + PW'(1);
            end
        end
    end

    // Datapath registers
    always_ff @(posedge clk_i or negedge clrb_i) begin
        if (!clrb_i) begin
            coins_left_q <= '0;
            paid_cnt_q   <= '0;
            retry_q      <= '0;
            timer_q      <= '0;
            pulse_q      <= '0;
            gap_q        <= 1'b0;
        end else begin
            coins_left_q <= coins_left_d;
            paid_cnt_q   <= paid_cnt_d;
            retry_q      <= retry_d;
            timer_q      <= timer_d;
            pulse_q      <= pulse_d;
            gap_q        <= gap_d;
        end
    end

    // Moore outputs decoded from the current state
    always_comb begin
        pay_busy_o   = (state_q != S_IDLE);
        motor_o      = (state_q == S_DRIVE) && !gap_q;
        done_o       = (state_q == S_DONE);
        jam_o        = (state_q == S_JAM);
        coins_left_o = coins_left_q;
        paid_cnt_o   = paid_cnt_q;
    end

endmodule

// File: tb/tb_coin_hopper.sv
// Directed bench for coin_hopper: drives payout requests and sensor pulses,
// tracks motor pulses independently, and checks completions against a
// queue of expected paid counts.
module tb_coin_hopper;

    localparam int AMT_W     = 8;
    localparam int PULSE_CYC = 4;

    logic             clk;
    logic             clrb;
    logic             payReq;
    logic [AMT_W-1:0] payAmt;
    logic             coinSense;
    logic             jamClr;
    logic             payBusy;
    logic             motor;
    logic             done;
    logic             jam;
    logic [AMT_W-1:0] coinsLeft;
    logic [AMT_W-1:0] paidCnt;

    int checks   = 0;
    int failures = 0;

    int expPaidQ[$];

    int pulseCount = 0;
    int badLen     = 0;
    int curLen     = 0;
    bit motorPrev  = 1'b0;

    int baseP;
    int baseB;
    bit ok;

    coin_hopper dut (
        .clk_i        (clk),
        .clrb_i       (clrb),
        .pay_req_i    (payReq),
        .pay_amt_i    (payAmt),
        .coin_sense_i (coinSense),
        .jam_clr_i    (jamClr),
        .pay_busy_o   (payBusy),
        .motor_o      (motor),
        .done_o       (done),
        .jam_o        (jam),
        .coins_left_o (coinsLeft),
        .paid_cnt_o   (paidCnt)
    );

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Independent motor monitor: counts pulses and flags any pulse of the wrong length
    always @(negedge clk) begin
        if (motor) begin
            if (!motorPrev) pulseCount++;
            curLen++;
        end else begin
            if (motorPrev && curLen != PULSE_CYC) badLen++;
            curLen = 0;
        end
        motorPrev = motor;
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [AMT_W-1:0] amt, input bit expectDone, input int expPaid);
        @(negedge clk);
        payReq = 1'b1;
        payAmt = amt;
        if (expectDone) expPaidQ.push_back(expPaid);
        @(negedge clk);
        payReq = 1'b0;
    endtask

    task automatic waitMotor(input string tag);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (motor) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checkOutput(tag, ok, 1);
    endtask

    task automatic waitPaid(input string tag, input int n);
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (paidCnt == AMT_W'(n)) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checkOutput(tag, ok, 1);
    endtask

    task automatic serveCoin(input string tag, input int expPaid);
        waitMotor({tag, "_motor"});
        repeat (2) @(negedge clk);
        coinSense = 1'b1;
        repeat (2) @(negedge clk);
        coinSense = 1'b0;
        waitPaid({tag, "_paid"}, expPaid);
    endtask

    task automatic waitDone(input string tag);
        int exp;
        ok = 1'b0;
        for (int i = 0; i < 150; i++) begin
            if (done) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checkOutput({tag, "_done_seen"}, ok, 1);
        checkOutput({tag, "_sb_nonempty"}, (expPaidQ.size() > 0), 1);
        exp = (expPaidQ.size() > 0) ? expPaidQ.pop_front() : -1;
        checkOutput({tag, "_paid"}, paidCnt, exp);
        checkOutput({tag, "_left"}, coinsLeft, 0);
        checkOutput({tag, "_busy_in_done"}, payBusy, 1);
        @(negedge clk);
        checkOutput({tag, "_done_1cyc"}, done, 0);
        checkOutput({tag, "_busy_after"}, payBusy, 0);
        checkOutput({tag, "_paid_hold"}, paidCnt, exp);
    endtask

    // Directed test sequence
    initial begin
        clrb      = 1'b0;
        payReq    = 1'b0;
        payAmt    = '0;
        coinSense = 1'b0;
        jamClr    = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rst_busy", payBusy, 0);
        checkOutput("rst_motor", motor, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_jam", jam, 0);
        checkOutput("rst_left", coinsLeft, 0);
        checkOutput("rst_paid", paidCnt, 0);
        clrb = 1'b1;
        repeat (2) @(negedge clk);

        // Test 1: three coins, each confirmed promptly
        $display("[TB] test 1: pay 3");
        #1 baseP = pulseCount; baseB = badLen;
        applyStimulus(8'd3, 1'b1, 3);
        checkOutput("t1_load_left", coinsLeft, 3);
        checkOutput("t1_load_busy", payBusy, 1);
        checkOutput("t1_load_motor", motor, 0);
        @(negedge clk);
        checkOutput("t1_motor_T2", motor, 1);
        serveCoin("t1_c1", 1);
        serveCoin("t1_c2", 2);
        serveCoin("t1_c3", 3);
        waitDone("t1");
        #1;
        checkOutput("t1_pulses", pulseCount - baseP, 3);
        checkOutput("t1_badlen", badLen - baseB, 0);

        // Test 2: zero-coin payout completes without motor activity
        $display("[TB] test 2: pay 0");
        #1 baseP = pulseCount;
        applyStimulus(8'd0, 1'b1, 0);
        checkOutput("t2_T1_done", done, 0);
        checkOutput("t2_T1_busy", payBusy, 1);
        @(negedge clk);
        checkOutput("t2_T2_done", done, 1);
        waitDone("t2");
        #1;
        checkOutput("t2_pulses", pulseCount - baseP, 0);

        // Test 3: silent sensor -> retries then jam; clear and confirm
        $display("[TB] test 3: jam");
        #1 baseP = pulseCount; baseB = badLen;
        applyStimulus(8'd1, 1'b1, 1);
        ok = 1'b0;
        for (int i = 0; i < 150; i++) begin
            if (jam) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checkOutput("t3_jam_seen", ok, 1);
        #1;
        checkOutput("t3_pulses", pulseCount - baseP, 3);
        checkOutput("t3_badlen", badLen - baseB, 0);
        checkOutput("t3_jam_motor", motor, 0);
        checkOutput("t3_jam_busy", payBusy, 1);
        checkOutput("t3_jam_paid", paidCnt, 0);
        repeat (5) @(negedge clk);
        checkOutput("t3_jam_stays", jam, 1);
        jamClr = 1'b1;
        @(negedge clk);
        jamClr = 1'b0;
        checkOutput("t3_clr_jam", jam, 0);
        serveCoin("t3_c1", 1);
        checkOutput("t3_done_nojam", jam, 0);
        waitDone("t3");

        // Test 4: second request mid-payout is ignored
        $display("[TB] test 4: pay 5 with ignored request");
        applyStimulus(8'd5, 1'b1, 5);
        serveCoin("t4_c1", 1);
        serveCoin("t4_c2", 2);
        applyStimulus(8'd9, 1'b0, 0);
        checkOutput("t4_ign_left", coinsLeft, 3);
        checkOutput("t4_ign_paid", paidCnt, 2);
        checkOutput("t4_ign_busy", payBusy, 1);
        for (int k = 3; k <= 5; k++) begin
            serveCoin("t4_c", k);
            checkOutput("t4_left_seq", coinsLeft, 5 - k);
        end
        waitDone("t4");

        // Test 5: sensor held high counts once, fresh pulse finishes
        $display("[TB] test 5: held sensor");
        applyStimulus(8'd2, 1'b1, 2);
        waitMotor("t5_motor");
        repeat (2) @(negedge clk);
        coinSense = 1'b1;
        repeat (40) @(negedge clk);
        checkOutput("t5_held_paid", paidCnt, 1);
        checkOutput("t5_held_left", coinsLeft, 1);
        checkOutput("t5_held_jam", jam, 0);
        coinSense = 1'b0;
        repeat (4) @(negedge clk);
        coinSense = 1'b1;
        repeat (2) @(negedge clk);
        coinSense = 1'b0;
        waitPaid("t5_paid2", 2);
        waitDone("t5");

        // Test 6: asynchronous reset mid-DRIVE, then normal payout
        $display("[TB] test 6: reset mid-drive");
        applyStimulus(8'd3, 1'b0, 0);
        waitMotor("t6_motor");
        @(negedge clk);
        clrb = 1'b0;
        #1;
        checkOutput("t6_rst_motor", motor, 0);
        checkOutput("t6_rst_busy", payBusy, 0);
        checkOutput("t6_rst_jam", jam, 0);
        checkOutput("t6_rst_left", coinsLeft, 0);
        checkOutput("t6_rst_paid", paidCnt, 0);
        @(negedge clk);
        clrb = 1'b1;
        @(negedge clk);
        checkOutput("t6_idle_busy", payBusy, 0);
        applyStimulus(8'd2, 1'b1, 2);
        serveCoin("t6_c1", 1);
        serveCoin("t6_c2", 2);
        waitDone("t6");
        checkOutput("t6_sb_empty", expPaidQ.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
